// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the aux master,
// the data-memory arbiter and the data memory itself.
interface dmem_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             cpu_req;
    logic             cpu_we;
    logic [2:0]       cpu_mode;
    logic [WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0] cpu_wdata;
    logic             cpu_gnt;
    logic             cpu_stall;
    logic [WIDTH-1:0] cpu_rdata;

    logic             aux_req;
    logic             aux_lock;
    logic             aux_we;
    logic [2:0]       aux_mode;
    logic [WIDTH-1:0] aux_addr;
    logic [WIDTH-1:0] aux_wdata;
    logic             aux_gnt;
    logic [WIDTH-1:0] aux_rdata;
    logic             aux_rvalid;

    logic [2:0]       mem_mode;
    logic [WIDTH-1:0] mem_A;
    logic [WIDTH-1:0] mem_WD;
    logic             mem_WE;
    logic [WIDTH-1:0] mem_RD;

    logic             misalign_err;
    logic             owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_stall, cpu_rdata,
        input  aux_req, aux_lock, aux_we, aux_mode, aux_addr, aux_wdata,
        output aux_gnt, aux_rdata, aux_rvalid,
        output mem_mode, mem_A, mem_WD, mem_WE,
        input  mem_RD,
        output misalign_err, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_mode, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_stall, cpu_rdata,
        output aux_req, aux_lock, aux_we, aux_mode, aux_addr, aux_wdata,
        input  aux_gnt, aux_rdata, aux_rvalid,
        input  mem_mode, mem_A, mem_WD, mem_WE,
        output mem_RD,
        input  misalign_err, owner
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU priority, aux anti-starvation,
// locked aux bursts, and write suppression for bad accesses.
module dmem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_MAX    = 8
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_MAX);

    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
    localparam logic [BW-1:0] BURST_ONE  = BW'(1);

    localparam logic [2:0] MODE_W  = 3'b001;
    localparam logic [2:0] MODE_H  = 3'b010;
    localparam logic [2:0] MODE_B  = 3'b011;
    localparam logic [2:0] MODE_HU = 3'b100;
    localparam logic [2:0] MODE_BU = 3'b101;

    typedef enum logic {
        S_CPU = 1'b0,
        S_AUX = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    state_t          cur_state;
    logic [SW-1:0]   starve_q;
    logic [SW-1:0]   starve_d;
    logic [BW-1:0]   burst_q;
    logic [BW-1:0]   burst_d;

    logic            cpu_gnt;
    logic            aux_gnt;
    logic            any_gnt;
    logic            force_aux;
    logic            sel_we;
    logic [2:0]      sel_mode;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic            access_bad;

    logic            err_q;
    logic            rvalid_q;
    logic [WIDTH-1:0] rdata_q;

    // True for misaligned or undefined-mode accesses.
    function automatic logic mode_bad(input logic [2:0] mode,
                                      input logic [1:0] lsb);
        case (mode)
            MODE_W:          return lsb != 2'b00;
            MODE_H, MODE_HU: return lsb[0];
            MODE_B, MODE_BU: return 1'b0;
            default:         return 1'b1;
        endcase
    endfunction

    // While reset is held the combinational side behaves as S_CPU.
    assign cur_state = rst ? S_CPU : state_q;
    assign force_aux = bus.aux_req && (starve_q == STARVE_TOP);

    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (cur_state == S_CPU) begin
            priority case (1'b1)
                force_aux:   aux_gnt = 1'b1;
                bus.cpu_req: cpu_gnt = 1'b1;
                bus.aux_req: aux_gnt = 1'b1;
                default: ;
            endcase
        end else begin
            priority case (1'b1)
                bus.aux_req: aux_gnt = 1'b1;
                bus.cpu_req: cpu_gnt = 1'b1;
                default: ;
            endcase
        end
    end

    assign any_gnt = cpu_gnt | aux_gnt;

    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        starve_d = starve_q;
        unique case (cur_state)
            S_CPU: begin
                if (aux_gnt && bus.aux_lock) begin
                    state_d = S_AUX;
                    burst_d = BURST_ONE;
                end
            end
            S_AUX: begin
                if (!bus.aux_req) begin
                    state_d = S_CPU;
                    burst_d = '0;
                end else if (!bus.aux_lock || burst_q == BURST_LAST) begin
                    state_d = S_CPU;
                    burst_d = '0;
                end else begin
                    burst_d = burst_q + BURST_ONE;
                end
            end
            default: ;
        endcase
        if (!bus.aux_req || aux_gnt) begin
            starve_d = '0;
        end else if (cur_state == S_CPU && starve_q != STARVE_TOP) begin
            starve_d = starve_q + STARVE_ONE;
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_mode  = 3'b000;
        sel_addr  = '0;
        sel_wdata = '0;
        if (cpu_gnt) begin
            sel_we    = bus.cpu_we;
            sel_mode  = bus.cpu_mode;
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
        end else if (aux_gnt) begin
            sel_we    = bus.aux_we;
            sel_mode  = bus.aux_mode;
            sel_addr  = bus.aux_addr;
            sel_wdata = bus.aux_wdata;
        end
    end

    assign access_bad = any_gnt && mode_bad(sel_mode, sel_addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_CPU;
            starve_q <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            burst_q  <= burst_d;
            err_q    <= access_bad;
            rvalid_q <= aux_gnt && !bus.aux_we;
            if (aux_gnt && !bus.aux_we) begin
                rdata_q <= bus.mem_RD;
            end
        end
    end

    assign bus.cpu_gnt      = cpu_gnt;
    assign bus.cpu_stall    = bus.cpu_req & ~cpu_gnt;
    assign bus.cpu_rdata    = bus.mem_RD;
    assign bus.aux_gnt      = aux_gnt;
    assign bus.aux_rdata    = rdata_q;
    assign bus.aux_rvalid   = rvalid_q;
    assign bus.mem_mode     = sel_mode;
    assign bus.mem_A        = sel_addr;
    assign bus.mem_WD       = sel_wdata;
    assign bus.mem_WE       = sel_we & ~access_bad;
    assign bus.misalign_err = err_q;
    assign bus.owner        = (state_q == S_AUX);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table for single-cycle behaviour,
// hand sequences for starvation, bursts, loads and reset.
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    logic preload;

    dmem_arbiter_if #(.WIDTH(32)) bus ();

    dmem_arbiter #(
        .WIDTH(32),
        .STARVE_LIMIT(4),
        .BURST_MAX(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    logic [31:0] tb_mem [0:63];

    assign bus.mem_RD = tb_mem[bus.mem_A[7:2]];

    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 64; k++) begin
                tb_mem[k] <= (k == 0) ? 32'hDEADBEEF : 32'h01010101 * k;
            end
        end else if (bus.mem_WE) begin
            tb_mem[bus.mem_A[7:2]] <= bus.mem_WD;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        err;
        logic        rv;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic        cr;
        logic        cw;
        logic [2:0]  cm;
        logic [31:0] ca;
        logic [31:0] cd;
        logic        ar;
        logic        aw;
        logic [2:0]  am;
        logic [31:0] aa;
        logic [31:0] ad;
        logic        gc;
        logic        ga;
        logic        st;
        logic [2:0]  mm;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic        we;
        logic        err;
        logic        rv;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_next(input logic err, input logic rv,
                               input logic [31:0] rd);
        exp_t e;
        e.err = err;
        e.rv  = rv;
        e.rd  = rd;
        exp_q.push_back(e);
    endtask

    // Advance one cycle and score the registered outputs it produced.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e.err = 1'b0;
            e.rv  = 1'b0;
            e.rd  = 32'h0;
        end
        chk("misalign_err", 32'(bus.misalign_err), 32'(e.err));
        chk("aux_rvalid", 32'(bus.aux_rvalid), 32'(e.rv));
        if (e.rv) begin
            chk("aux_rdata", bus.aux_rdata, e.rd);
        end
    endtask

    task automatic idle();
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_mode  = 3'd0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wdata = 32'h0;
        bus.aux_req   = 1'b0;
        bus.aux_lock  = 1'b0;
        bus.aux_we    = 1'b0;
        bus.aux_mode  = 3'd0;
        bus.aux_addr  = 32'h0;
        bus.aux_wdata = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic cpu_load(input logic [31:0] a);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_mode = 3'd1;
        bus.cpu_addr = a;
    endtask

    task automatic aux_op(input logic lock, input logic we,
                          input logic [31:0] a, input logic [31:0] d);
        bus.aux_req   = 1'b1;
        bus.aux_lock  = lock;
        bus.aux_we    = we;
        bus.aux_mode  = 3'd1;
        bus.aux_addr  = a;
        bus.aux_wdata = d;
    endtask

    initial begin
        rst     = 1'b1;
        preload = 1'b1;
        idle();
        @(posedge clk);
        #1;
        preload = 1'b0;
        tick();
        rst = 1'b0;
        #2;
        chk("rst_owner", 32'(bus.owner), 32'h0);
        chk("rst_rvalid", 32'(bus.aux_rvalid), 32'h0);
        chk("rst_rdata", bus.aux_rdata, 32'h0);
        chk("rst_err", 32'(bus.misalign_err), 32'h0);
        chk("idle_cpu_gnt", 32'(bus.cpu_gnt), 32'h0);
        chk("idle_aux_gnt", 32'(bus.aux_gnt), 32'h0);
        chk("idle_we", 32'(bus.mem_WE), 32'h0);
        chk("idle_mode", 32'(bus.mem_mode), 32'h0);
        chk("idle_addr", bus.mem_A, 32'h0);

        vt[0]  = '{1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 3'd1, 32'h10004, 32'h0,
                   1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 3'd1, 32'h10004, 32'h0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 3'd1, 32'h10008, 32'hA5A50001,
                   1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 3'd1, 32'h10008, 32'hA5A50001, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 3'd1, 32'h10002, 32'h11111111,
                   1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 3'd1, 32'h10002, 32'h11111111, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b1, 3'd7, 32'h10000, 32'h22222222,
                   1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 3'd7, 32'h10000, 32'h22222222, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b1, 3'd2, 32'h10022, 32'h00003333,
                   1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 3'd2, 32'h10022, 32'h00003333, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b1, 3'd4, 32'h10021, 32'h00000044,
                   1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 3'd4, 32'h10021, 32'h00000044, 1'b0, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 1'b0, 3'd1, 32'h10004, 32'h0,
                   1'b1, 1'b1, 3'd1, 32'h10030, 32'h00000055,
                   1'b1, 1'b0, 1'b0, 3'd1, 32'h10004, 32'h0, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b1, 1'b1, 3'd1, 32'h10030, 32'h66666666,
                   1'b0, 1'b1, 1'b0, 3'd1, 32'h10030, 32'h66666666, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b1, 1'b0, 3'd0, 32'h10010, 32'h0,
                   1'b0, 1'b1, 1'b0, 3'd0, 32'h10010, 32'h0, 1'b0, 1'b1, 1'b1};
        vt[10] = '{1'b1, 1'b0, 3'd3, 32'h10003, 32'h0,
                   1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 3'd3, 32'h10003, 32'h0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b1, 3'd0, 32'h10014, 32'h00000077,
                   1'b0, 1'b0, 3'd0, 32'h0, 32'h0,
                   1'b1, 1'b0, 1'b0, 3'd0, 32'h10014, 32'h00000077, 1'b0, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b1, 3'd1, 32'h10008, 32'h00000099,
                   1'b1, 1'b0, 3'd1, 32'h10000, 32'h0,
                   1'b0, 1'b1, 1'b0, 3'd1, 32'h10000, 32'h0, 1'b0, 1'b0, 1'b1};

        for (int i = 0; i < 13; i++) begin
            do_reset();
            bus.cpu_req   = vt[i].cr;
            bus.cpu_we    = vt[i].cw;
            bus.cpu_mode  = vt[i].cm;
            bus.cpu_addr  = vt[i].ca;
            bus.cpu_wdata = vt[i].cd;
            bus.aux_req   = vt[i].ar;
            bus.aux_lock  = 1'b0;
            bus.aux_we    = vt[i].aw;
            bus.aux_mode  = vt[i].am;
            bus.aux_addr  = vt[i].aa;
            bus.aux_wdata = vt[i].ad;
            #2;
            chk($sformatf("v%0d_cpu_gnt", i), 32'(bus.cpu_gnt), 32'(vt[i].gc));
            chk($sformatf("v%0d_aux_gnt", i), 32'(bus.aux_gnt), 32'(vt[i].ga));
            chk($sformatf("v%0d_stall", i), 32'(bus.cpu_stall), 32'(vt[i].st));
            chk($sformatf("v%0d_mode", i), 32'(bus.mem_mode), 32'(vt[i].mm));
            chk($sformatf("v%0d_addr", i), bus.mem_A, vt[i].ma);
            chk($sformatf("v%0d_wd", i), bus.mem_WD, vt[i].mwd);
            chk($sformatf("v%0d_we", i), 32'(bus.mem_WE), 32'(vt[i].we));
            if (vt[i].gc) begin
                chk($sformatf("v%0d_cpu_rdata", i), bus.cpu_rdata,
                    tb_mem[vt[i].ca[7:2]]);
            end
            expect_next(vt[i].err, vt[i].rv, tb_mem[vt[i].aa[7:2]]);
            tick();
        end

        chk("mem_unchanged", tb_mem[0], 32'hDEADBEEF);
        chk("cpu_store_commit", tb_mem[2], 32'hA5A50001);
        chk("aux_store_commit", tb_mem[12], 32'h66666666);

        // Forced aux grant after STARVE_LIMIT denied cycles.
        do_reset();
        cpu_load(32'h10004);
        aux_op(1'b0, 1'b0, 32'h10000, 32'h0);
        for (int c = 0; c < 6; c++) begin
            #2;
            chk($sformatf("starve_c%0d_aux_gnt", c), 32'(bus.aux_gnt), 32'(c == 4));
            chk($sformatf("starve_c%0d_cpu_gnt", c), 32'(bus.cpu_gnt), 32'(c != 4));
            chk($sformatf("starve_c%0d_stall", c), 32'(bus.cpu_stall), 32'(c == 4));
            expect_next(1'b0, c == 4, 32'hDEADBEEF);
            tick();
            if (c == 4) begin
                chk("starve_cleared", 32'(dut.starve_q), 32'h0);
            end
        end

        // Burst cap: forced entry then BURST_MAX locked beats.
        do_reset();
        cpu_load(32'h10004);
        aux_op(1'b1, 1'b1, 32'h10040, 32'h000000BB);
        for (int c = 0; c < 13; c++) begin
            #2;
            chk($sformatf("burst_c%0d_owner", c), 32'(bus.owner),
                32'(c >= 5 && c <= 11));
            chk($sformatf("burst_c%0d_aux_gnt", c), 32'(bus.aux_gnt),
                32'(c >= 4 && c <= 11));
            chk($sformatf("burst_c%0d_cpu_gnt", c), 32'(bus.cpu_gnt),
                32'(c < 4 || c > 11));
            tick();
        end

        // Back-to-back aux loads.
        do_reset();
        aux_op(1'b0, 1'b0, 32'h10000, 32'h0);
        #2;
        expect_next(1'b0, 1'b1, 32'hDEADBEEF);
        tick();
        bus.aux_addr = 32'h10004;
        #2;
        chk("b2b_aux_gnt", 32'(bus.aux_gnt), 32'h1);
        expect_next(1'b0, 1'b1, 32'h01010101);
        tick();
        idle();
        tick();
        chk("rdata_hold", bus.aux_rdata, 32'h01010101);

        // Reset at burst beat 3.
        do_reset();
        aux_op(1'b1, 1'b0, 32'h10000, 32'h0);
        for (int c = 0; c < 2; c++) begin
            #2;
            chk($sformatf("rb_c%0d_aux_gnt", c), 32'(bus.aux_gnt), 32'h1);
            expect_next(1'b0, 1'b1, 32'hDEADBEEF);
            tick();
        end
        rst = 1'b1;
        cpu_load(32'h10004);
        #2;
        chk("rb_owner_before", 32'(bus.owner), 32'h1);
        chk("rb_rst_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
        chk("rb_rst_aux_gnt", 32'(bus.aux_gnt), 32'h0);
        tick();
        chk("rb_owner", 32'(bus.owner), 32'h0);
        chk("rb_rdata", bus.aux_rdata, 32'h0);
        chk("rb_burst_cnt", 32'(dut.burst_q), 32'h0);
        chk("rb_starve_cnt", 32'(dut.starve_q), 32'h0);
        rst = 1'b0;
        #2;
        chk("rb_post_cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
        chk("rb_post_aux_gnt", 32'(bus.aux_gnt), 32'h0);
        tick();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
